// File: rtl/ff_layer_scheduler_if.sv
// Handshake bundle between the layer scheduler and its environment.
//   Host request  : req_valid, req_ready, req_train, req_is_positive
//   Datapath pulse: fwd/good/plast start (scheduler -> datapath) and done (datapath -> scheduler)
//   Context       : layer_sel, plast_is_positive
// Modports:
//   slave  - the scheduler
//   master - host plus datapath blocks (drive requests and done pulses)
interface ff_layer_scheduler_if #(
  parameter int unsigned NUM_LAYERS = 2
);
  localparam int unsigned LselW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic             req_valid;
  logic             req_ready;
  logic             req_train;
  logic             req_is_positive;
  logic [LselW-1:0] layer_sel;
  logic             fwd_start;
  logic             fwd_done;
  logic             good_start;
  logic             good_done;
  logic             plast_start;
  logic             plast_done;
  logic             plast_is_positive;

  modport slave (
    input  req_valid, req_train, req_is_positive, fwd_done, good_done, plast_done,
    output req_ready, layer_sel, fwd_start, good_start, plast_start, plast_is_positive
  );

  modport master (
    output req_valid, req_train, req_is_positive, fwd_done, good_done, plast_done,
    input  req_ready, layer_sel, fwd_start, good_start, plast_start, plast_is_positive
  );
endinterface

// File: rtl/ff_layer_scheduler.sv
// Per-sample sequencer for a forward-forward network. For each layer it issues
// forward -> goodness -> (train only) plasticity, waiting for each done pulse under
// a watchdog. A timeout parks the FSM in ERROR until err_clear.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   bus (slave)   - request handshake, start/done pulse pairs, layer_sel, plast_is_positive
//   busy          - FSM not in IDLE
//   sample_done   - one-cycle pulse when a sample completes
//   sample_count  - saturating count of completed samples
//   err/err_clear - sticky timeout flag and its clear
module ff_layer_scheduler #(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ff_layer_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 sample_done,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 err,
  input  logic                 err_clear
);

  localparam int unsigned LselW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LselW-1:0] LastLayer = LselW'(NUM_LAYERS - 1);
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StFwd,
    StFwdWait,
    StGood,
    StGoodWait,
    StPlast,
    StPlastWait,
    StDone,
    StError
  } state_e;

  state_e           state_q;
  logic [WdogW-1:0] wdog_q;
  logic             mode_train_q;
  logic             mode_pos_q;

  assign busy          = (state_q != StIdle);
  assign bus.req_ready = (state_q == StIdle) && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= StIdle;
      wdog_q                <= '0;
      mode_train_q          <= 1'b0;
      mode_pos_q            <= 1'b0;
      bus.layer_sel         <= '0;
      bus.fwd_start         <= 1'b0;
      bus.good_start        <= 1'b0;
      bus.plast_start       <= 1'b0;
      bus.plast_is_positive <= 1'b0;
      sample_done           <= 1'b0;
      sample_count          <= '0;
      err                   <= 1'b0;
    end else begin
      // Start and done pulses are asserted on the transition into their state,
      // so they are high for exactly that one cycle.
      bus.fwd_start   <= 1'b0;
      bus.good_start  <= 1'b0;
      bus.plast_start <= 1'b0;
      sample_done     <= 1'b0;

      case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            mode_train_q  <= bus.req_train;
            mode_pos_q    <= bus.req_is_positive;
            bus.layer_sel <= '0;
            bus.fwd_start <= 1'b1;
            state_q       <= StFwd;
          end
        end
        // Done inputs are not looked at in the start states, so a done
        // coincident with its start pulse is dropped.
        StFwd: begin
          wdog_q  <= '0;
          state_q <= StFwdWait;
        end
        StFwdWait: begin
          if (bus.fwd_done) begin
            bus.good_start <= 1'b1;
            state_q        <= StGood;
          end else if (wdog_q == WdogLimit) begin
            err     <= 1'b1;
            state_q <= StError;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        StGood: begin
          wdog_q  <= '0;
          state_q <= StGoodWait;
        end
        StGoodWait: begin
          if (bus.good_done) begin
            if (mode_train_q) begin
              bus.plast_start       <= 1'b1;
              bus.plast_is_positive <= mode_pos_q;
              state_q               <= StPlast;
            end else if (bus.layer_sel == LastLayer) begin
              sample_done <= 1'b1;
              state_q     <= StDone;
            end else begin
              bus.layer_sel <= bus.layer_sel + LselW'(1);
              bus.fwd_start <= 1'b1;
              state_q       <= StFwd;
            end
          end else if (wdog_q == WdogLimit) begin
            err     <= 1'b1;
            state_q <= StError;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        StPlast: begin
          wdog_q  <= '0;
          state_q <= StPlastWait;
        end
        StPlastWait: begin
          if (bus.plast_done) begin
            if (bus.layer_sel == LastLayer) begin
              sample_done <= 1'b1;
              state_q     <= StDone;
            end else begin
              bus.layer_sel <= bus.layer_sel + LselW'(1);
              bus.fwd_start <= 1'b1;
              state_q       <= StFwd;
            end
          end else if (wdog_q == WdogLimit) begin
            err     <= 1'b1;
            state_q <= StError;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        StDone: begin
          if (sample_count != '1) begin
            sample_count <= sample_count + CNT_WIDTH'(1);
          end
          state_q <= StIdle;
        end
        StError: begin
          if (err_clear) begin
            err     <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_layer_scheduler.sv
`timescale 1ns/1ps
module tb_ff_layer_scheduler;
  localparam int unsigned NL = 2;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          err_clear;
  logic          busy;
  logic          sample_done;
  logic          err;
  logic [CW-1:0] sample_count;

  ff_layer_scheduler_if #(.NUM_LAYERS(NL)) bus ();

  ff_layer_scheduler #(
    .NUM_LAYERS    (NL),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .sample_done (sample_done),
    .sample_count(sample_count),
    .err         (err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_errors = 0;
  int            start_log[$];   // kind*100 + layer*10 + polarity (plast only)
  int            done_cnt = 0;
  int            hs_cnt = 0;
  int            lsel_bad = 0;
  int            fixed_lat = 0;  // 0 = random latency 1..8
  bit            coin_en = 1'b0;
  bit            withhold_good = 1'b0;
  bit            stray_en = 1'b0;
  logic [CW-1:0] exp_count = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observer: handshakes, completions and every start pulse, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.req_valid && bus.req_ready) hs_cnt++;
        if (sample_done) done_cnt++;
        if (bus.fwd_start) start_log.push_back(100 + 10 * int'(bus.layer_sel));
        if (bus.good_start) start_log.push_back(200 + 10 * int'(bus.layer_sel));
        if (bus.plast_start)
          start_log.push_back(300 + 10 * int'(bus.layer_sel) + int'(bus.plast_is_positive));
      end
    end
  end

  task automatic drive_done(input int k);
    case (k)
      0:       bus.fwd_done = 1'b1;
      1:       bus.good_done = 1'b1;
      default: bus.plast_done = 1'b1;
    endcase
  endtask

  // Datapath stand-in: answers each start with a done after a latency.
  initial begin
    bit   pend [3];
    int   cnt  [3];
    int   lyr  [3];
    int   stray_cnt;
    logic st   [3];
    bus.fwd_done   = 1'b0;
    bus.good_done  = 1'b0;
    bus.plast_done = 1'b0;
    stray_cnt      = 0;
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
    forever begin
      @(negedge clk);
      bus.fwd_done   = 1'b0;
      bus.good_done  = 1'b0;
      bus.plast_done = 1'b0;
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) pend[k] = 1'b0;
        stray_cnt = 0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (pend[k]) begin
            if (int'(bus.layer_sel) != lyr[k]) lsel_bad++;
            cnt[k]--;
            if (cnt[k] == 0) begin
              pend[k] = 1'b0;
              drive_done(k);
            end
          end
        end
        if (stray_cnt > 0) begin
          stray_cnt--;
          if (stray_cnt == 0) bus.fwd_done = 1'b1;
        end
        st[0] = bus.fwd_start;
        st[1] = bus.good_start && !withhold_good;
        st[2] = bus.plast_start;
        for (int k = 0; k < 3; k++) begin
          if (st[k]) begin
            pend[k] = 1'b1;
            cnt[k]  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
            lyr[k]  = int'(bus.layer_sel);
            if (coin_en) drive_done(k);
          end
        end
        if (bus.plast_start && stray_en) stray_cnt = 1;
      end
    end
  end

  // One full sample against the reference sequence built from the mode rules.
  task automatic run_sample(input bit train, input bit pos, input bit hold_valid,
                            input string tag);
    int base, hs0, dn0, n, got;
    int exp_log[$];
    for (int l = 0; l < int'(NL); l++) begin
      exp_log.push_back(100 + 10 * l);
      exp_log.push_back(200 + 10 * l);
      if (train) exp_log.push_back(300 + 10 * l + int'(pos));
    end
    n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    base = start_log.size();
    hs0  = hs_cnt;
    dn0  = done_cnt;
    bus.req_valid       = 1'b1;
    bus.req_train       = train;
    bus.req_is_positive = pos;
    step();
    check_eq($sformatf("%s/accept", tag), {busy, bus.fwd_start, bus.layer_sel}, 3'b110);
    if (!hold_valid) bus.req_valid = 1'b0;
    bus.req_train       = 1'($urandom);
    bus.req_is_positive = 1'($urandom);
    n = 0;
    while (!sample_done && n < 400) begin
      step();
      n++;
    end
    check_eq($sformatf("%s/done_seen", tag), sample_done, 1);
    bus.req_valid = 1'b0;
    step();
    if (exp_count != '1) exp_count = exp_count + 1;
    check_eq($sformatf("%s/count", tag), sample_count, exp_count);
    check_eq($sformatf("%s/idle", tag), {busy, bus.req_ready, err}, 3'b010);
    check_eq($sformatf("%s/nstarts", tag), start_log.size() - base, exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      got = (base + i < start_log.size()) ? start_log[base + i] : -1;
      check_eq($sformatf("%s/seq%0d", tag, i), got, exp_log[i]);
    end
    check_eq($sformatf("%s/ndone", tag), done_cnt - dn0, 1);
    check_eq($sformatf("%s/nhs", tag), hs_cnt - hs0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          n, dn0, base;
    int unsigned g;
    rst_n               = 1'b1;
    err_clear           = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_train       = 1'b0;
    bus.req_is_positive = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check_eq("reset/flags", {busy, bus.req_ready, bus.fwd_start, bus.good_start,
             bus.plast_start, bus.plast_is_positive, sample_done, err}, 8'b0100_0000);
    check_eq("reset/layer", bus.layer_sel, 0);
    check_eq("reset/count", sample_count, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    fixed_lat = 3;
    run_sample(1'b0, 1'b1, 1'b0, "inf");
    run_sample(1'b1, 1'b0, 1'b0, "trn_neg");

    fixed_lat = 0;
    for (int i = 0; i < 16; i++) begin
      coin_en = 1'($urandom);
      run_sample(1'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) step();
    end
    coin_en = 1'b0;

    // Stray fwd_done in PLAST_WAIT, req_valid held through the whole sample.
    stray_en  = 1'b1;
    fixed_lat = 5;
    run_sample(1'b1, 1'b1, 1'b1, "stray");
    stray_en  = 1'b0;

    // Done arriving on the last watchdog cycle wins over the timeout.
    fixed_lat = int'(TO);
    run_sample(1'b0, 1'b0, 1'b0, "edge");

    // Withheld good_done: timeout, error hold, clear.
    fixed_lat     = 3;
    withhold_good = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_train = 1'b0;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.good_start && n < 50) begin
      step();
      n++;
    end
    g = cyc;
    n = 0;
    while (!err && n < 60) begin
      step();
      n++;
    end
    check_eq("tmo/latency", cyc - g, 17);
    check_eq("tmo/state", {err, busy, bus.req_ready}, 3'b110);
    base = start_log.size();
    repeat (5) step();
    check_eq("tmo/no_starts", start_log.size() - base, 0);
    check_eq("tmo/held", {err, busy}, 2'b11);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_eq("tmo/cleared", {err, busy, bus.req_ready}, 3'b001);
    check_eq("tmo/count", sample_count, exp_count);
    withhold_good = 1'b0;

    // err_clear while not in error changes nothing.
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    check_eq("clr_noop/state", {err, busy, bus.req_ready}, 3'b001);
    check_eq("clr_noop/count", sample_count, exp_count);

    // Reset during PLAST_WAIT of the last layer.
    fixed_lat           = 4;
    bus.req_valid       = 1'b1;
    bus.req_train       = 1'b1;
    bus.req_is_positive = 1'b1;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.plast_start && bus.layer_sel == 1'b1) && n < 200) begin
      step();
      n++;
    end
    check_eq("rst/plast_l1", {bus.plast_start, bus.plast_is_positive, bus.layer_sel}, 3'b111);
    step();
    dn0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst/flags", {busy, bus.req_ready, bus.fwd_start, bus.good_start,
             bus.plast_start, bus.plast_is_positive, sample_done, err}, 8'b0100_0000);
    check_eq("rst/layer", bus.layer_sel, 0);
    check_eq("rst/count", sample_count, 0);
    exp_count = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check_eq("rst/no_done", done_cnt - dn0, 0);
    check_eq("rst/idle", {busy, bus.req_ready}, 2'b01);

    // Saturation at all-ones.
    fixed_lat = 0;
    force dut.sample_count = '1;
    step();
    release dut.sample_count;
    exp_count = '1;
    step();
    check_eq("sat/preload", sample_count, exp_count);
    run_sample(1'b1, 1'b1, 1'b0, "sat");

    check_eq("layer_stable", lsel_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
